// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the push-button debouncer.
//   state_t : debouncer FSM state, 2-bit encoding
//   cnt_w   : width of the consecutive-sample counter for a given N_SAMPLES
//   hold_w  : width of the long-press tick counter for a given HOLD_TICKS
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  function automatic int cnt_w(input int n_samples);
    return $clog2(n_samples + 1);
  endfunction

  function automatic int hold_w(input int hold_ticks);
    return $clog2(hold_ticks + 1);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side bundle of the debouncer.
//   slow_clk    : divider output, each 0->1 transition is one sample tick
//   btn_raw     : raw asynchronous button pin, 1 = pressed
//   btn_level   : debounced level
//   btn_press   : one-clk pulse on accepted press
//   btn_release : one-clk pulse on accepted release
//   btn_hold    : one-clk pulse on long press, at most once per press
// master drives the pin and strobe; slave is the debouncer.
interface button_debouncer_if;
  logic slow_clk;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_hold;

  modport master (
    output slow_clk, btn_raw,
    input  btn_level, btn_press, btn_release, btn_hold
  );

  modport slave (
    input  slow_clk, btn_raw,
    output btn_level, btn_press, btn_release, btn_hold
  );
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin, synchronous active-high reset.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer driven by the slow_clk sample strobe.
//   clk   : system clock, every flop is on its rising edge
//   reset : synchronous, active-high
//   bus   : button_debouncer_if.slave (slow_clk, btn_raw in; level/press/release/hold out)
// btn_raw is synchronized, then sampled once per slow_clk rising edge. A state change is
// accepted after N_SAMPLES consecutive equal samples; btn_hold fires once per press after
// HOLD_TICKS ticks spent pressed.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_SAMPLES  = 4,
  parameter int HOLD_TICKS = 8
) (
  input logic               clk,
  input logic               reset,
  button_debouncer_if.slave bus
);

  localparam int CNT_W  = cnt_w(N_SAMPLES);
  localparam int HOLD_W = hold_w(HOLD_TICKS);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    return (v >= HOLD_MAX) ? HOLD_MAX : v + HOLD_W'(1);
  endfunction

  logic btn_s;
  logic slow_clk_d;
  logic tick;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              hold_done, hold_done_nxt;
  logic              hold_fire;

  logic level_nxt, press_nxt, release_nxt, hold_nxt;
  logic level_q, press_q, release_q, hold_q;

  // Input stage: synchronizer and sample-strobe edge detect
  sync_2ff u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_raw),
    .q     (btn_s)
  );

  // slow_clk_d resets high so a slow_clk already high at reset release is not a tick.
  always_ff @(posedge clk) begin
    if (reset) slow_clk_d <= 1'b1;
    else       slow_clk_d <= bus.slow_clk;
  end

  assign tick = bus.slow_clk & ~slow_clk_d;

  // FSM stage: state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= CNT_ZERO;
      hold_cnt  <= HOLD_ZERO;
      hold_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      hold_done <= hold_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hold_cnt_nxt = hold_cnt;
    if (tick) begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state_nxt = PRESS_CHK;
            cnt_nxt   = CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!btn_s) begin
            state_nxt = IDLE;
            cnt_nxt   = CNT_ZERO;
          end else if (cnt == CNT_LAST) begin
            state_nxt    = PRESSED;
            cnt_nxt      = CNT_ZERO;
            hold_cnt_nxt = HOLD_ZERO;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_nxt = RELEASE_CHK;
            cnt_nxt   = CNT_ONE;
          end else begin
            hold_cnt_nxt = hold_sat_inc(hold_cnt);
          end
        end
        RELEASE_CHK: begin
          // A bounce back to 1 returns to PRESSED with the long-press progress intact.
          if (btn_s) begin
            state_nxt = PRESSED;
            cnt_nxt   = CNT_ZERO;
          end else if (cnt == CNT_LAST) begin
            state_nxt    = IDLE;
            cnt_nxt      = CNT_ZERO;
            hold_cnt_nxt = HOLD_ZERO;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // hold_done latches the first long-press pulse and is only cleared back in IDLE.
  assign hold_fire = tick && (state == PRESSED) && btn_s &&
                     (hold_cnt_nxt == HOLD_MAX) && !hold_done;

  always_comb begin
    hold_done_nxt = hold_done;
    if (state_nxt == IDLE) hold_done_nxt = 1'b0;
    else if (hold_fire)    hold_done_nxt = 1'b1;
  end

  // Output stage: next-cycle values, registered so they align with the new state
  always_comb begin
    level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
    press_nxt   = tick && (state == PRESS_CHK) && (state_nxt == PRESSED);
    release_nxt = tick && (state == RELEASE_CHK) && (state_nxt == IDLE);
    hold_nxt    = hold_fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      hold_q    <= hold_nxt;
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_hold    = hold_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with N_SAMPLES=4, HOLD_TICKS=8, slow_clk period 8 clk.
module tb_button_debouncer;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  button_debouncer_if bus ();

  button_debouncer #(
    .N_SAMPLES  (4),
    .HOLD_TICKS (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  // Pulse counters: a pulse longer than one cycle counts more than once.
  int n_press   = 0;
  int n_release = 0;
  int n_hold    = 0;
  int n_overlap = 0;

  always @(posedge clk) begin
    n_press   <= n_press   + int'(bus.btn_press);
    n_release <= n_release + int'(bus.btn_release);
    n_hold    <= n_hold    + int'(bus.btn_hold);
    if ((int'(bus.btn_press) + int'(bus.btn_release) + int'(bus.btn_hold)) > 1)
      n_overlap <= n_overlap + 1;
  end

  // One sample tick, period 8 clk: slow_clk high 3 more cycles, low 4, then rises.
  // Returns at the negedge right after the tick edge, where registered pulses are visible.
  task automatic do_tick(input logic b);
    bus.btn_raw = b;
    repeat (3) @(negedge clk);
    bus.slow_clk = 1'b0;
    repeat (4) @(negedge clk);
    bus.slow_clk = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.slow_clk = 1'b1;
    bus.btn_raw  = 1'b1;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold} !== 4'b0000)
      $display("FAIL reset_outputs got=%b want=0000",
               {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold});
    else passed++;
    total++;
    if (dut.state !== IDLE) $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE);
    else passed++;
    reset = 1'b0;
    total++;
    if (dut.tick !== 1'b0) $display("FAIL no_tick_after_reset got=%b want=0", dut.tick);
    else passed++;
    repeat (4) @(negedge clk);
    total++;
    if (dut.state !== IDLE || dut.cnt !== 3'd0)
      $display("FAIL idle_without_tick state=%0d cnt=%0d want IDLE/0", dut.state, dut.cnt);
    else passed++;
  endtask

  task automatic test_press();
    int p0;
    p0 = n_press;
    for (int i = 1; i <= 4; i++) begin
      do_tick(1'b1);
      total++;
      if (bus.btn_press !== (i == 4))
        $display("FAIL press_tick%0d got=%b want=%b", i, bus.btn_press, (i == 4));
      else passed++;
      total++;
      if (bus.btn_level !== (i == 4))
        $display("FAIL level_tick%0d got=%b want=%b", i, bus.btn_level, (i == 4));
      else passed++;
    end
    @(negedge clk);
    total++;
    if (bus.btn_press !== 1'b0 || bus.btn_level !== 1'b1)
      $display("FAIL press_after press=%b level=%b want 0/1", bus.btn_press, bus.btn_level);
    else passed++;
    total++;
    if (n_press - p0 !== 1) $display("FAIL press_count got=%0d want=1", n_press - p0);
    else passed++;
  endtask

  task automatic test_hold();
    int h0, p0;
    h0 = n_hold;
    p0 = n_press;
    for (int i = 1; i <= 8; i++) begin
      do_tick(1'b1);
      total++;
      if (bus.btn_hold !== (i == 8))
        $display("FAIL hold_tick%0d got=%b want=%b", i, bus.btn_hold, (i == 8));
      else passed++;
    end
    for (int i = 0; i < 10; i++) do_tick(1'b1);
    total++;
    if (n_hold - h0 !== 1 || n_press - p0 !== 0)
      $display("FAIL hold_once hold=%0d press=%0d want 1/0", n_hold - h0, n_press - p0);
    else passed++;
  endtask

  task automatic test_release_bounce();
    logic pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int p0, r0, h0;
    p0 = n_press;
    r0 = n_release;
    h0 = n_hold;
    for (int i = 0; i < 6; i++) begin
      do_tick(pat[i]);
      total++;
      if (bus.btn_level !== (i < 5) || bus.btn_release !== (i == 5))
        $display("FAIL release_tick%0d level=%b rel=%b want %b/%b",
                 i, bus.btn_level, bus.btn_release, (i < 5), (i == 5));
      else passed++;
    end
    @(negedge clk);
    total++;
    if (n_press - p0 !== 0 || n_release - r0 !== 1 || n_hold - h0 !== 0)
      $display("FAIL release_counts press=%0d rel=%0d hold=%0d want 0/1/0",
               n_press - p0, n_release - r0, n_hold - h0);
    else passed++;
  endtask

  task automatic test_press_bounce();
    logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int p0, h0, r0;
    p0 = n_press;
    h0 = n_hold;
    r0 = n_release;
    for (int i = 0; i < 7; i++) begin
      do_tick(pat[i]);
      total++;
      if (bus.btn_press !== (i == 6) || bus.btn_level !== (i == 6))
        $display("FAIL bounce_tick%0d press=%b level=%b want %b/%b",
                 i, bus.btn_press, bus.btn_level, (i == 6), (i == 6));
      else passed++;
    end
    for (int i = 1; i <= 8; i++) begin
      do_tick(1'b1);
      total++;
      if (bus.btn_hold !== (i == 8))
        $display("FAIL fresh_hold_tick%0d got=%b want=%b", i, bus.btn_hold, (i == 8));
      else passed++;
    end
    for (int i = 1; i <= 4; i++) begin
      do_tick(1'b0);
      total++;
      if (bus.btn_release !== (i == 4) || bus.btn_level !== (i != 4))
        $display("FAIL clean_release_tick%0d rel=%b level=%b want %b/%b",
                 i, bus.btn_release, bus.btn_level, (i == 4), (i != 4));
      else passed++;
    end
    @(negedge clk);
    total++;
    if (n_press - p0 !== 1 || n_hold - h0 !== 1 || n_release - r0 !== 1)
      $display("FAIL bounce_counts press=%0d hold=%0d rel=%0d want 1/1/1",
               n_press - p0, n_hold - h0, n_release - r0);
    else passed++;
  endtask

  task automatic test_reset_mid_check_and_stall();
    int p0, r0, h0;
    for (int i = 0; i < 3; i++) do_tick(1'b1);
    total++;
    if (dut.state !== PRESS_CHK || dut.cnt !== 3'd3)
      $display("FAIL mid_check state=%0d cnt=%0d want %0d/3", dut.state, dut.cnt, PRESS_CHK);
    else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if (dut.state !== IDLE || dut.cnt !== 3'd0 || bus.btn_level !== 1'b0)
      $display("FAIL mid_reset state=%0d cnt=%0d level=%b want IDLE/0/0",
               dut.state, dut.cnt, bus.btn_level);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      do_tick(1'b1);
      total++;
      if (bus.btn_press !== (i == 4))
        $display("FAIL post_reset_tick%0d press=%b want=%b", i, bus.btn_press, (i == 4));
      else passed++;
    end
    @(negedge clk);
    p0 = n_press;
    r0 = n_release;
    h0 = n_hold;
    bus.btn_raw = 1'b0;
    repeat (50) @(negedge clk);
    total++;
    if (bus.btn_level !== 1'b1 || dut.state !== PRESSED)
      $display("FAIL stall_frozen level=%b state=%0d want 1/%0d", bus.btn_level, dut.state, PRESSED);
    else passed++;
    total++;
    if (n_press - p0 !== 0 || n_release - r0 !== 0 || n_hold - h0 !== 0)
      $display("FAIL stall_pulses press=%0d rel=%0d hold=%0d want 0/0/0",
               n_press - p0, n_release - r0, n_hold - h0);
    else passed++;
  endtask

  task automatic test_exclusive();
    total++;
    if (n_overlap !== 0) $display("FAIL pulse_overlap got=%0d want=0", n_overlap);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_press();
    test_hold();
    test_release_bounce();
    test_press_bounce();
    test_reset_mid_check_and_stall();
    test_exclusive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
